codificador_piso_grey: RTL and testbench
========================================

// Module: codificador_piso_grey
// PURPOSE
//   Elevator car position tracker/encoder. Accepts a destination floor and steps
//   the car position one floor per T_PASO clock cycles toward it. Publishes the
//   position in binary and in registered Gray code (exactly one bit changes per
//   floor step).
//   Transmit-side counterpart of the Gray->binary decoder on the floor-display path.
// PARAMETERS
//   N_BITS    3    width of floor number (binary and Gray)
//   PISO_MAX  7    highest valid floor; must satisfy PISO_MAX <= 2**N_BITS-1
//   T_PASO    16   clock cycles of travel per floor; must be >= 1
// PORTS
//   clk_i          in   1       system clock, rising edge
//   rst_i          in   1       synchronous reset, active-high
//   destino_i      in   N_BITS  requested destination floor, binary
//   solicitud_i    in   1       1-cycle request strobe; destino_i sampled with it
//   ocupado_o      out  1       car moving or arriving; new requests ignored
//   subiendo_o     out  1       car moving up (state SUBE)
//   bajando_o      out  1       car moving down (state BAJA)
//   llegada_o      out  1       1-cycle pulse: car at destination
//   error_o        out  1       1-cycle pulse: request with destino_i > PISO_MAX
//   piso_bin_o     out  N_BITS  current floor, binary, registered
//   piso_grey_o    out  N_BITS  current floor, Gray, registered
// BEHAVIOUR
//   Reset (rst_i=1 at an edge): state REPOSO; piso=0; timer=0; destino reg=0.
//     All outputs 0, including piso_bin_o and piso_grey_o.
//     Reset mid-travel aborts immediately; no llegada_o pulse is produced.
//   States: REPOSO, SUBE, BAJA, LLEGA.
//   REPOSO, solicitud_i=1 at edge k:
//     - destino_i > PISO_MAX: error_o=1 for cycle k+1; stay REPOSO.
//     - destino_i == piso: go to LLEGA (llegada_o=1 for cycle k+1).
//     - destino_i > piso: latch destino; timer=0; go to SUBE.
//     - destino_i < piso: latch destino; timer=0; go to BAJA.
//   SUBE/BAJA:
//     - Timer counts 0..T_PASO-1.
//     - At the edge where timer==T_PASO-1: piso +/-1; timer=0.
//     - If the new piso == destino, the next state is LLEGA; otherwise stay.
//     - First floor change is T_PASO edges after acceptance.
//     - Total travel is |destino-piso|*T_PASO cycles, then one LLEGA cycle.
//   LLEGA: llegada_o=1 for exactly one cycle; then unconditionally REPOSO.
//   ocupado_o=1 in SUBE, BAJA and LLEGA.
//   solicitud_i while ocupado_o=1 is ignored: no queue, no error.
//     A request in the LLEGA cycle is also ignored.
//   piso_grey_o is updated on the same edge as piso_bin_o.
//     piso_grey_o == piso_bin_o ^ (piso_bin_o >> 1) at all times after reset.
//     It never shows an intermediate value.
//   piso never leaves 0..PISO_MAX; no wrap-around is possible by construction.
//   Timer width: $clog2(T_PASO+1) bits.
//   Floor arithmetic is unsigned N_BITS-bit.
//   All outputs are driven directly from registers or state decode; no
//     combinational path from inputs to outputs.
// STRUCTURE
//   Shared package/include (piso_pkg):
//     - state encodings REPOSO=2'd0, SUBE=2'd1, BAJA=2'd2, LLEGA=2'd3
//     - default N_BITS/PISO_MAX constants shared with the display decoder
//   Sub-module cod_bin_a_grey:
//     - N_BITS combinational binary->Gray converter (XOR of adjacent bits)
//     - output registered inside this block
//     - pairs with the existing Gray->binary decoder for loopback tests
// TESTING
//   1 Reset: hold rst_i 2 cycles during SUBE
//       -> next cycle all outputs 0, state REPOSO.
//   2 From floor 0, destino_i=5, T_PASO=16:
//       -> subiendo_o=1; piso_grey_o walks 000,001,011,010,110,111;
//       -> one change every 16 cycles; llegada_o pulses at cycle 81.
//   3 From floor 5, destino_i=2:
//       -> bajando_o=1; piso_bin_o 5,4,3,2;
//       -> each step changes exactly one Gray bit; llegada_o once; then REPOSO.
//   4 destino_i == current floor (3)
//       -> llegada_o=1 on the next cycle only; piso unchanged; ocupado_o for 1 cycle.
//   5 PISO_MAX=5, destino_i=6
//       -> error_o 1-cycle pulse; state and piso unchanged.
//   6 Request mid-travel, and a request in the LLEGA cycle
//       -> both ignored; destination unchanged.
//   Every cycle: check the Gray invariant; loopback through the Gray->binary
//     decoder must equal piso_bin_o.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared definitions for the elevator floor path: FSM state encodings and the
// default floor-number geometry also used by the Gray->binary display decoder.
package piso_pkg;

  localparam int N_BITS_DEF   = 3;
  localparam int PISO_MAX_DEF = 7;

  typedef enum logic [1:0] {
    REPOSO = 2'd0,
    SUBE   = 2'd1,
    BAJA   = 2'd2,
    LLEGA  = 2'd3
  } estado_t;

endpackage

// File: rtl/cod_bin_a_grey.sv
// Binary -> Gray converter with a registered output. It is fed with the next
// floor so the Gray code changes on the same edge as the binary floor register.
module cod_bin_a_grey #(
  parameter int N_BITS = piso_pkg::N_BITS_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [N_BITS-1:0] bin_i,
  output logic [N_BITS-1:0] grey_o
);

  logic [N_BITS-1:0] w_grey;
  logic [N_BITS-1:0] r_grey;

  assign w_grey = bin_i ^ (bin_i >> 1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_grey <= '0;
    end else begin
      r_grey <= w_grey;
    end
  end

  assign grey_o = r_grey;

endmodule

// File: rtl/codificador_piso_grey.sv
// Elevator car position tracker: steps the floor one position every T_PASO
// cycles toward the requested destination and publishes it in binary and Gray.
module codificador_piso_grey
  import piso_pkg::*;
#(
  parameter int N_BITS   = N_BITS_DEF,
  parameter int PISO_MAX = PISO_MAX_DEF,
  parameter int T_PASO   = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [N_BITS-1:0] destino_i,
  input  logic              solicitud_i,
  output logic              ocupado_o,
  output logic              subiendo_o,
  output logic              bajando_o,
  output logic              llegada_o,
  output logic              error_o,
  output logic [N_BITS-1:0] piso_bin_o,
  output logic [N_BITS-1:0] piso_grey_o
);

  localparam int                TW         = $clog2(T_PASO + 1);
  localparam logic [TW-1:0]     TIMER_FIN  = TW'(T_PASO - 1);
  localparam logic [N_BITS-1:0] PISO_MAX_V = N_BITS'(PISO_MAX);

  estado_t           r_estado, w_estado_sig;
  logic [N_BITS-1:0] r_piso, w_piso_sig;
  logic [N_BITS-1:0] r_destino, w_destino_sig;
  logic [TW-1:0]     r_timer, w_timer_sig;
  logic              r_error, w_error_sig;
  logic [N_BITS-1:0] w_piso_paso;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_estado  <= REPOSO;
      r_piso    <= '0;
      r_destino <= '0;
      r_timer   <= '0;
      r_error   <= 1'b0;
    end else begin
      r_estado  <= w_estado_sig;
      r_piso    <= w_piso_sig;
      r_destino <= w_destino_sig;
      r_timer   <= w_timer_sig;
      r_error   <= w_error_sig;
    end
  end

  // Neighbouring floor in the current direction of travel.
  assign w_piso_paso = (r_estado == SUBE) ? (r_piso + N_BITS'(1)) : (r_piso - N_BITS'(1));

  always_comb begin
    w_estado_sig  = r_estado;
    w_piso_sig    = r_piso;
    w_destino_sig = r_destino;
    w_timer_sig   = r_timer;
    w_error_sig   = 1'b0;
    case (r_estado)
      REPOSO: begin
        if (solicitud_i) begin
          if (destino_i > PISO_MAX_V) begin
            w_error_sig = 1'b1;
          end else if (destino_i == r_piso) begin
            w_estado_sig = LLEGA;
          end else begin
            w_destino_sig = destino_i;
            w_timer_sig   = '0;
            w_estado_sig  = (destino_i > r_piso) ? SUBE : BAJA;
          end
        end else begin
          w_estado_sig = REPOSO;
        end
      end
      SUBE, BAJA: begin
        if (r_timer == TIMER_FIN) begin
          w_timer_sig = '0;
          w_piso_sig  = w_piso_paso;
          if (w_piso_paso == r_destino) begin
            w_estado_sig = LLEGA;
          end else begin
            w_estado_sig = r_estado;
          end
        end else begin
          w_timer_sig = r_timer + TW'(1);
        end
      end
      LLEGA:   w_estado_sig = REPOSO;
      default: w_estado_sig = REPOSO;
    endcase
  end

  cod_bin_a_grey #(
    .N_BITS (N_BITS)
  ) u_cod_bin_a_grey (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .bin_i  (w_piso_sig),
    .grey_o (piso_grey_o)
  );

  assign ocupado_o  = (r_estado != REPOSO);
  assign subiendo_o = (r_estado == SUBE);
  assign bajando_o  = (r_estado == BAJA);
  assign llegada_o  = (r_estado == LLEGA);
  assign error_o    = r_error;
  assign piso_bin_o = r_piso;

endmodule

// File: tb/tb_codificador_piso_grey.sv
// Directed plus randomized bench for codificador_piso_grey, checked every cycle
// against a timeline model of the car (start floor, destination, elapsed edges).
module tb_codificador_piso_grey;

  localparam int NB = 3;
  localparam int PM = 5;
  localparam int TP = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] destino = '0;
  logic          solicitud = 1'b0;
  logic          ocupado, subiendo, bajando, llegada, error_p;
  logic [NB-1:0] piso_bin, piso_grey;

  codificador_piso_grey #(.N_BITS(NB), .PISO_MAX(PM), .T_PASO(TP)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .destino_i   (destino),
    .solicitud_i (solicitud),
    .ocupado_o   (ocupado),
    .subiendo_o  (subiendo),
    .bajando_o   (bajando),
    .llegada_o   (llegada),
    .error_o     (error_p),
    .piso_bin_o  (piso_bin),
    .piso_grey_o (piso_grey)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: a trip is described by where it started, where it goes and
  // how many edges have elapsed since it was accepted.
  bit m_active = 1'b0;
  int m_floor  = 0;
  int m_start  = 0;
  int m_dest   = 0;
  int m_n      = 0;
  bit m_err    = 1'b0;

  function automatic int dist_of(input int a, input int b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  function automatic int exp_floor();
    int d, k;
    if (!m_active) return m_floor;
    d = dist_of(m_start, m_dest);
    k = (m_n / TP < d) ? (m_n / TP) : d;
    return (m_dest > m_start) ? (m_start + k) : (m_start - k);
  endfunction

  function automatic logic [NB-1:0] grey_a_bin(input logic [NB-1:0] g);
    logic [NB-1:0] b;
    b[NB-1] = g[NB-1];
    for (int i = NB - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic model_edge(input logic r, input logic s, input int d);
    bit was_idle;
    if (r) begin
      m_active = 1'b0; m_floor = 0; m_err = 1'b0;
    end else begin
      was_idle = !m_active;
      m_err = 1'b0;
      if (m_active) begin
        m_n++;
        if (m_n > dist_of(m_start, m_dest) * TP) begin
          m_active = 1'b0;
          m_floor  = m_dest;
        end
      end
      if (was_idle && s) begin
        if (d > PM) m_err = 1'b1;
        else begin
          m_active = 1'b1; m_start = m_floor; m_dest = d; m_n = 0;
        end
      end
    end
  endtask

  task automatic tick(input logic r, input logic s, input logic [NB-1:0] d);
    int f, tt;
    bit moving;
    logic [NB-1:0] fb;
    rst = r; solicitud = s; destino = d;
    @(posedge clk);
    model_edge(r, s, int'(d));
    #1;
    f  = exp_floor();
    fb = NB'(f);
    tt = dist_of(m_start, m_dest) * TP;
    moving = m_active && (m_n < tt);
    chk("piso_bin",  32'(piso_bin), 32'(fb));
    chk("piso_grey", 32'(piso_grey), 32'(fb ^ (fb >> 1)));
    chk("grey_invariant", 32'(piso_grey), 32'(piso_bin ^ (piso_bin >> 1)));
    chk("loopback", 32'(grey_a_bin(piso_grey)), 32'(fb));
    chk("ocupado",  32'(ocupado),  32'(m_active));
    chk("subiendo", 32'(subiendo), 32'(moving && (m_dest > m_start)));
    chk("bajando",  32'(bajando),  32'(moving && (m_dest < m_start)));
    chk("llegada",  32'(llegada),  32'(m_active && (m_n == tt)));
    chk("error",    32'(error_p),  32'(m_err));
    solicitud = 1'b0;
  endtask

  logic [NB-1:0] seq_q[$];
  logic [NB-1:0] exp_seq [6];
  logic [NB-1:0] prev_g;

  initial begin
    exp_seq = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111};

    // Power-up reset
    tick(1'b1, 1'b0, 3'd0);
    tick(1'b1, 1'b0, 3'd0);

    // 0 -> 5: Gray walk, arrival pulse 81 cycles after the request edge
    tick(1'b0, 1'b1, 3'd5);
    seq_q.push_back(piso_grey);
    for (int i = 1; i <= 80; i++) begin
      tick(1'b0, 1'b0, 3'd0);
      if (i % TP == 0) seq_q.push_back(piso_grey);
    end
    chk("t2_llegada_81", 32'(llegada), 32'd1);
    for (int i = 0; i < 6; i++) chk("t2_grey_seq", 32'(seq_q[i]), 32'(exp_seq[i]));
    tick(1'b0, 1'b0, 3'd0);
    chk("t2_idle", 32'(ocupado), 32'd0);

    // 5 -> 2: every step flips a single Gray bit
    tick(1'b0, 1'b1, 3'd2);
    prev_g = piso_grey;
    for (int i = 0; i < 3 * TP + 2; i++) begin
      tick(1'b0, 1'b0, 3'd0);
      if (piso_grey != prev_g) chk("t3_one_bit", 32'($countones(piso_grey ^ prev_g)), 32'd1);
      prev_g = piso_grey;
    end

    // 2 -> 4 with a request mid-travel and one in the arrival cycle
    tick(1'b0, 1'b1, 3'd4);
    for (int i = 1; i < 2 * TP; i++) tick(1'b0, (i == 10), 3'd0);
    tick(1'b0, 1'b0, 3'd0);
    tick(1'b0, 1'b1, 3'd1);
    tick(1'b0, 1'b0, 3'd0);
    chk("t6_dest_kept", 32'(piso_bin), 32'd4);

    // 4 -> 3, then a request for the current floor
    tick(1'b0, 1'b1, 3'd3);
    for (int i = 0; i < TP + 1; i++) tick(1'b0, 1'b0, 3'd0);
    tick(1'b0, 1'b1, 3'd3);
    tick(1'b0, 1'b0, 3'd0);
    tick(1'b0, 1'b0, 3'd0);

    // Out-of-range destinations
    tick(1'b0, 1'b1, 3'd6);
    tick(1'b0, 1'b0, 3'd0);
    tick(1'b0, 1'b1, 3'd7);
    tick(1'b0, 1'b0, 3'd0);

    // Reset held two cycles while climbing
    tick(1'b0, 1'b1, 3'd5);
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, 3'd0);
    tick(1'b1, 1'b0, 3'd0);
    tick(1'b1, 1'b0, 3'd0);
    tick(1'b0, 1'b0, 3'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++)
      tick(($urandom_range(0, 399) == 0), ($urandom_range(0, 7) == 0), NB'($urandom_range(0, 7)));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
